stage_if_fetch: RTL

Parametrised instruction-fetch front end that supersedes the bare PC register. It owns the fetch PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a small queue. It presents those instructions to decode with a valid/ready handshake and handles jump/branch redirects, including discarding responses that are already in flight.

---
 rtl/if_pkg.sv | 31 +++
 rtl/fetch_queue.sv | 83 ++++++++
 rtl/stage_if_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end.
package if_pkg;

  localparam int XLEN_DEF = 32;

  // Queue entry layout at the default width.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic                pending;
    logic                fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JUMP
  } redir_e;

  function automatic redir_e redir_sel(
    input logic jump,
    input logic branch
  );
    redir_e s;
    s = RD_NONE;
    if (jump) s = RD_JUMP;
    else if (branch) s = RD_BRANCH;
    return s;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at request time
// and filled as responses return; read side feeds decode.
module fetch_queue
  import if_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [XLEN-1:0]       alloc_pc_i,
  input  logic                  fault_i,
  input  logic [XLEN-1:0]       fault_pc_i,
  input  logic                  fill_i,
  input  logic [XLEN-1:0]       fill_data_i,
  input  logic                  pop_i,
  output logic [$clog2(DEPTH):0] used_o,
  output logic [$clog2(DEPTH):0] pend_o,
  output logic                  head_valid_o,
  output logic [XLEN-1:0]       head_pc_o,
  output logic [XLEN-1:0]       head_instr_o,
  output logic                  head_fault_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pending;
    logic            fault;
  } entry_t;

  entry_t mem_q [DEPTH];
  ptr_t   alloc_q;
  ptr_t   fill_q;
  ptr_t   rd_q;
  entry_t head;

  assign used_o       = alloc_q - rd_q;
  assign pend_o       = alloc_q - fill_q;
  assign head         = mem_q[rd_q[AW-1:0]];
  assign head_valid_o = (used_o != '0) && !head.pending;
  assign head_pc_o    = head.pc;
  assign head_instr_o = head.instr;
  assign head_fault_o = head.fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else if (flush_i) begin
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else begin
      if (alloc_i) begin
        mem_q[alloc_q[AW-1:0]] <= '{pc: alloc_pc_i, instr: '0,
                                   pending: 1'b1, fault: 1'b0};
        alloc_q <= alloc_q + 1'b1;
      end else if (fault_i) begin
        // Fault entries are born complete; no response will come.
        mem_q[alloc_q[AW-1:0]] <= '{pc: fault_pc_i, instr: '0,
                                   pending: 1'b0, fault: 1'b1};
        alloc_q <= alloc_q + 1'b1;
        fill_q  <= fill_q + 1'b1;
      end
      if (fill_i) begin
        mem_q[fill_q[AW-1:0]].instr   <= fill_data_i;
        mem_q[fill_q[AW-1:0]].pending <= 1'b0;
        fill_q <= fill_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/stage_if_fetch.sv
// Fetch front end: PC, request credits, redirect drop tracking.
// IF_MISALIGN_CHECK_EN turns misaligned targets into fault entries.
module stage_if_fetch
  import if_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            do_branch,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            do_jump,
  input  logic [XLEN-1:0] jump_addr,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_instr,
  output logic            out_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef IF_MISALIGN_CHECK_EN
  localparam bit MisalignEn = 1'b1;
`else
  localparam bit MisalignEn = 1'b0;
`endif

  redir_e          sel;
  logic            redirect;
  logic            misalign;
  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   used, pend, credit, pend_sum;
  logic            halted_q, halted_d;
  logic            fpend_q, fpend_d;
  logic            fire, fill, pop, fault_enq;
  logic            head_fault;

  assign sel      = redir_sel(do_jump, do_branch);
  assign redirect = (sel != RD_NONE);

  always_comb begin
    raw_tgt = branch_addr;
    unique case (sel)
      RD_JUMP: raw_tgt = jump_addr;
      default: raw_tgt = branch_addr;
    endcase
  end

  assign misalign = MisalignEn && (raw_tgt[1:0] != 2'b00);
  assign target   = MisalignEn ? raw_tgt
                               : {raw_tgt[XLEN-1:2], 2'b00};

  // Stale responses still occupy memory-side slots until they drain.
  assign credit    = used + drop_q;
  assign req_valid = en && !reset && !redirect && !halted_q
                     && (credit < DEPTH_C);
  assign req_addr  = pc_q;
  assign fire      = req_valid && req_ready;
  assign fill      = resp_valid && !redirect
                     && (drop_q == '0) && (pend != '0);
  assign pop       = out_valid && out_ready && !redirect;
  assign fault_enq = fpend_q && !redirect && (drop_q == '0);

  always_comb begin
    pend_sum = pend + drop_q;
    drop_d   = drop_q;
    if (redirect) begin
      if (resp_valid && pend_sum != '0) pend_sum = pend_sum - CW'(1);
      drop_d = pend_sum;
    end else if (resp_valid && drop_q != '0) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    fpend_d  = fpend_q && !fault_enq;
    fpc_d    = fpc_q;
    if (redirect) begin
      pc_d     = target;
      halted_d = misalign;
      fpend_d  = misalign;
      fpc_d    = target;
    end else if (fire) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      fpc_q    <= '0;
      drop_q   <= '0;
      halted_q <= 1'b0;
      fpend_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      fpc_q    <= fpc_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
      fpend_q  <= fpend_d;
    end
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect),
    .alloc_i      (fire),
    .alloc_pc_i   (pc_q),
    .fault_i      (fault_enq),
    .fault_pc_i   (fpc_q),
    .fill_i       (fill),
    .fill_data_i  (resp_data),
    .pop_i        (pop),
    .used_o       (used),
    .pend_o       (pend),
    .head_valid_o (out_valid),
    .head_pc_o    (out_pc),
    .head_instr_o (out_instr),
    .head_fault_o (head_fault)
  );

  assign out_pc_plus4 = out_pc + XLEN'(4);
  assign out_fault    = MisalignEn && head_fault;

  a_resp_tracked: assert property (@(posedge clk) disable iff (reset)
    resp_valid |-> (pend != '0 || drop_q != '0));

endmodule
